// File: rtl/bs_addsub_lanes.sv
// Multi-lane bit-serial two's-complement adder/subtractor, LSB-first, with word
// framing, stall support and per-lane carry-out / signed-overflow flags on the MSB.
module bs_addsub_lanes #(
   parameter int LANES  = 4,
   parameter int WORD_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             start,
   input  logic             sub,
   input  logic [LANES-1:0] x,
   input  logic [LANES-1:0] y,
   output logic [LANES-1:0] z,
   output logic             z_valid,
   output logic             z_last,
   output logic [LANES-1:0] cout,
   output logic [LANES-1:0] ovf
);

   localparam int CNT_W = $clog2(WORD_W);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [CNT_W-1:0] r_bitCnt;
   logic [CNT_W-1:0] w_nextCnt;
   logic [CNT_W-1:0] w_bitIdx;
   logic [LANES-1:0] r_carry;
   logic             r_mode;

   logic             w_take;
   logic             w_isLast;
   logic             w_mode;
   logic [LANES-1:0] w_yy;
   logic [LANES-1:0] w_cin;
   logic [LANES-1:0] w_sum;
   logic [LANES-1:0] w_carry;

   // A start always restarts framing at bit 0, even mid-word; non-start bits
   // only count while a word is in flight.
   always_comb begin
      w_take   = in_valid && (start || (r_state == RUN));
      w_bitIdx = start ? '0 : r_bitCnt;
      w_isLast = (w_bitIdx == CNT_W'(WORD_W - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_bitCnt <= '0;
      end else begin
         r_state  <= w_nextState;
         r_bitCnt <= w_nextCnt;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_bitCnt;
      if (w_take) begin
         if (w_isLast) begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
         end else begin
            w_nextState = RUN;
            w_nextCnt   = w_bitIdx + 1'b1;
         end
      end
   end

   // Subtraction is x + ~y + 1: invert y and inject the mode as carry-in at bit 0.
   always_comb begin
      w_mode  = start ? sub : r_mode;
      w_yy    = y ^ {LANES{w_mode}};
      w_cin   = start ? {LANES{w_mode}} : r_carry;
      w_sum   = x ^ w_yy ^ w_cin;
      w_carry = (x & w_yy) | (x & w_cin) | (w_yy & w_cin);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_carry <= '0;
         r_mode  <= 1'b0;
      end else if (w_take) begin
         r_carry <= w_carry;
         r_mode  <= w_mode;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         z       <= '0;
         z_valid <= 1'b0;
         z_last  <= 1'b0;
         cout    <= '0;
         ovf     <= '0;
      end else begin
         z_valid <= w_take;
         z_last  <= w_take && w_isLast;
         if (w_take) begin
            z <= w_sum;
         end
         cout <= (w_take && w_isLast) ? w_carry : '0;
         ovf  <= (w_take && w_isLast) ? (w_carry ^ w_cin) : '0;
      end
   end

endmodule

// File: doc/bs_addsub_lanes.md
Name: bs_addsub_lanes

Overview:
- Multi-lane, parametrised successor to the single-bit serial adder.
- LANES independent bit-serial channels. Each channel adds or subtracts two's-complement words of WORD_W bits, streamed LSB-first, one bit per accepted cycle.
- Provides word framing, stall support, and per-lane carry-out and signed-overflow flags.
- Sits between serial operand sources and serial accumulators in the datapath.

Parameters:
- LANES, 4, number of independent serial channels.
- WORD_W, 8, bits per word (>=2); sets the bit-counter range 0..WORD_W-1.

Ports:
- clk     input   1      rising-edge clock
- rst     input   1      asynchronous, active-low reset
- in_valid input  1      x/y/start/sub carry a bit this cycle; bit accepted only when high
- start   input   1      accepted bit is bit 0 (LSB) of a new word
- sub     input   1      mode; sampled only on an accepted start bit; 1 = x-y, 0 = x+y
- x       input   LANES  operand A bit, one per lane
- y       input   LANES  operand B bit, one per lane
- z       output  LANES  registered result bit, one per lane
- z_valid output  1      z holds a valid result bit
- z_last  output  1      z holds the MSB of the word
- cout    output  LANES  final carry out of the MSB; valid when z_last=1, else 0
- ovf     output  LANES  signed overflow (carry into MSB xor carry out); valid when z_last=1, else 0

Behaviour:
- Reset (rst=0, async): state=IDLE, bit_cnt=0, carry regs=0, mode=0, and z, z_valid, z_last, cout, ovf all 0.
- States:
  - IDLE: waiting for an accepted start.
  - RUN: mid-word.
- Accepted bit: in_valid=1 at a clock edge. Cycles with in_valid=0 hold all internal state; outputs z_valid, z_last, cout and ovf go 0 on the next edge.
- IDLE behaviour:
  - Accepted bit with start=0 is ignored (z_valid stays 0).
  - Accepted bit with start=1 latches mode=sub, processes bit 0, sets bit_cnt=1, and moves to RUN.
- Per-lane bit operation:
  - yy = y xor mode.
  - cin = mode for bit 0, else the lane carry reg.
  - z = x^yy^cin; carry reg <= majority(x, yy, cin).
- Latency: z, z_valid and z_last are registered one cycle after the accepted bit.
- RUN behaviour:
  - Each accepted bit increments bit_cnt.
  - On bit WORD_W-1: z_last=1; cout=majority of the MSB terms; ovf=cin_msb xor cout. Then return to IDLE with bit_cnt=0.
- start=1 on an accepted bit while in RUN: abandon the current word (no z_last, no flags) and treat the bit as bit 0 of a new word, re-sampling sub.
- WORD_W=2 boundary: bit 0 goes IDLE->RUN, bit 1 asserts z_last and returns to IDLE. A start accepted on the cycle right after z_last begins a new word back-to-back with no bubble.
- Lanes share the framing (start, sub, bit_cnt) but keep independent carries. cout and ovf are per lane.
- Reset mid-word clears everything immediately. The partial word is discarded and no z_last is produced.

Test Plan:
- WORD_W=8, lane0: start+sub=0, stream x=100, y=27 over 8 cycles -> z bits form 127; z_last on 8th output; cout=0, ovf=0.
- Lane1 (same run): x=100, y=28 -> z=128 (0x80); ovf=1, cout=0. Lane2: x=0xFF, y=0x01 -> z=0x00; cout=1, ovf=0.
- sub=1, x=5, y=7 -> z=0xFE; cout=0 (borrow), ovf=0. Also x=0x80, y=0x01 -> z=0x7F; ovf=1, cout=1.
- Repeat 100+27 with in_valid=0 inserted randomly between bits -> identical z sequence. z_valid is low on stall-following cycles; z_last asserts exactly once.
- Drop rst at bit 4 -> all outputs 0 asynchronously. After release, a new start of 3+4 yields 7 with no leftover carry. Also re-assert start at bit 5 mid-word -> the old word produces no z_last, and the new word result is correct.
- Back-to-back: two words 1+1 then 2+2 with start on the cycle after the first bit 7 -> results 2 and 4, z_last on consecutive word boundaries, no gap.
